// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decode pipeline stage feeding the execute-stage ALU.
// Fetch hands over instr/pc_in on a valid/ready handshake. The stage decodes the
// instruction combinationally and registers the bundle towards execute.
// Optional feature macro: ID_SKID_BUFFER_EN adds a second (skid) entry, so
// in_ready becomes a flop with no combinational path from out_ready.
// ALU operation codes come from the ALUCTRL_* macros. The fallback encoding
// below is used only when alu_control_def.v has not been read in first.

`ifndef ALUCTRL_ADD
`define ALUCTRL_ADD   5'd0
`define ALUCTRL_SUB   5'd1
`define ALUCTRL_SLL   5'd2
`define ALUCTRL_SLT   5'd3
`define ALUCTRL_SLTU  5'd4
`define ALUCTRL_XOR   5'd5
`define ALUCTRL_SRL   5'd6
`define ALUCTRL_SRA   5'd7
`define ALUCTRL_OR    5'd8
`define ALUCTRL_AND   5'd9
`define ALUCTRL_BEQ   5'd10
`define ALUCTRL_BNE   5'd11
`define ALUCTRL_BLT   5'd12
`define ALUCTRL_BGE   5'd13
`define ALUCTRL_BLTU  5'd14
`define ALUCTRL_BGEU  5'd15
`define ALUCTRL_JAL   5'd16
`define ALUCTRL_JALR  5'd17
`define ALUCTRL_AUIPC 5'd18
`endif

module id_decode_stage #(
  parameter int XLEN      = 32,
  parameter int CTRL_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      instr,
  input  logic [XLEN-1:0]      pc_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      pc_out,
  output logic [CTRL_BITS-1:0] alu_ctrl,
  output logic                 alu_pcsrc,
  output logic                 alu_immsrc,
  output logic [XLEN-1:0]      imm,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 reg_wen,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [2:0]           mem_funct3,
  output logic                 illegal
);

  localparam logic [CTRL_BITS-1:0] C_ADD   = CTRL_BITS'(`ALUCTRL_ADD);
  localparam logic [CTRL_BITS-1:0] C_SUB   = CTRL_BITS'(`ALUCTRL_SUB);
  localparam logic [CTRL_BITS-1:0] C_SLL   = CTRL_BITS'(`ALUCTRL_SLL);
  localparam logic [CTRL_BITS-1:0] C_SLT   = CTRL_BITS'(`ALUCTRL_SLT);
  localparam logic [CTRL_BITS-1:0] C_SLTU  = CTRL_BITS'(`ALUCTRL_SLTU);
  localparam logic [CTRL_BITS-1:0] C_XOR   = CTRL_BITS'(`ALUCTRL_XOR);
  localparam logic [CTRL_BITS-1:0] C_SRL   = CTRL_BITS'(`ALUCTRL_SRL);
  localparam logic [CTRL_BITS-1:0] C_SRA   = CTRL_BITS'(`ALUCTRL_SRA);
  localparam logic [CTRL_BITS-1:0] C_OR    = CTRL_BITS'(`ALUCTRL_OR);
  localparam logic [CTRL_BITS-1:0] C_AND   = CTRL_BITS'(`ALUCTRL_AND);
  localparam logic [CTRL_BITS-1:0] C_BEQ   = CTRL_BITS'(`ALUCTRL_BEQ);
  localparam logic [CTRL_BITS-1:0] C_BNE   = CTRL_BITS'(`ALUCTRL_BNE);
  localparam logic [CTRL_BITS-1:0] C_BLT   = CTRL_BITS'(`ALUCTRL_BLT);
  localparam logic [CTRL_BITS-1:0] C_BGE   = CTRL_BITS'(`ALUCTRL_BGE);
  localparam logic [CTRL_BITS-1:0] C_BLTU  = CTRL_BITS'(`ALUCTRL_BLTU);
  localparam logic [CTRL_BITS-1:0] C_BGEU  = CTRL_BITS'(`ALUCTRL_BGEU);
  localparam logic [CTRL_BITS-1:0] C_JAL   = CTRL_BITS'(`ALUCTRL_JAL);
  localparam logic [CTRL_BITS-1:0] C_JALR  = CTRL_BITS'(`ALUCTRL_JALR);
  localparam logic [CTRL_BITS-1:0] C_AUIPC = CTRL_BITS'(`ALUCTRL_AUIPC);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [CTRL_BITS-1:0] alu_ctrl;
    logic                 pcsrc;
    logic                 immsrc;
    logic [XLEN-1:0]      imm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 reg_wen;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [2:0]           mem_funct3;
    logic                 illegal;
  } bundle_t;

  // Cleared bundle: a NOP (ADD) with every enable low.
  function automatic bundle_t clear_bundle();
    bundle_t b;
    b          = '0;
    b.alu_ctrl = C_ADD;
    return b;
  endfunction

  // Register/immediate ALU operation from funct3; alt selects SUB/SRA.
  function automatic logic [CTRL_BITS-1:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [CTRL_BITS-1:0] op;
    case (f3)
      3'b000:  op = alt ? C_SUB : C_ADD;
      3'b001:  op = C_SLL;
      3'b010:  op = C_SLT;
      3'b011:  op = C_SLTU;
      3'b100:  op = C_XOR;
      3'b101:  op = alt ? C_SRA : C_SRL;
      3'b110:  op = C_OR;
      3'b111:  op = C_AND;
      default: op = C_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_sh;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'h000}));
  assign imm_sh = XLEN'(instr[24:20]);

  bundle_t dec_bundle;
  logic    dec_bad;

  // Combinational decode of the incoming instruction into an execute bundle.
  always_comb begin
    dec_bundle    = clear_bundle();
    dec_bundle.pc = pc_in;
    dec_bad       = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_bundle.rs1     = instr[19:15];
        dec_bundle.rs2     = instr[24:20];
        dec_bundle.rd      = instr[11:7];
        dec_bundle.reg_wen = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_bundle.alu_ctrl = alu_op(funct3, 1'b0);
        end else if ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec_bundle.alu_ctrl = alu_op(funct3, 1'b1);
        end else begin
          dec_bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_bundle.immsrc  = 1'b1;
        dec_bundle.rs1     = instr[19:15];
        dec_bundle.rd      = instr[11:7];
        dec_bundle.reg_wen = 1'b1;
        case (funct3)
          3'b001: begin
            dec_bundle.imm      = imm_sh;
            dec_bundle.alu_ctrl = C_SLL;
            dec_bad             = (funct7 != 7'b0000000);
          end
          3'b101: begin
            dec_bundle.imm = imm_sh;
            if (funct7 == 7'b0000000) begin
              dec_bundle.alu_ctrl = C_SRL;
            end else if (funct7 == 7'b0100000) begin
              dec_bundle.alu_ctrl = C_SRA;
            end else begin
              dec_bad = 1'b1;
            end
          end
          default: begin
            dec_bundle.imm      = imm_i;
            dec_bundle.alu_ctrl = alu_op(funct3, 1'b0);
          end
        endcase
      end
      OPC_LOAD: begin
        dec_bundle.immsrc     = 1'b1;
        dec_bundle.imm        = imm_i;
        dec_bundle.rs1        = instr[19:15];
        dec_bundle.rd         = instr[11:7];
        dec_bundle.reg_wen    = 1'b1;
        dec_bundle.mem_ren    = 1'b1;
        dec_bundle.mem_funct3 = funct3;
        dec_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_bundle.immsrc     = 1'b1;
        dec_bundle.imm        = imm_s;
        dec_bundle.rs1        = instr[19:15];
        dec_bundle.rs2        = instr[24:20];
        dec_bundle.mem_wen    = 1'b1;
        dec_bundle.mem_funct3 = funct3;
        dec_bad = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec_bundle.imm = imm_b;
        dec_bundle.rs1 = instr[19:15];
        dec_bundle.rs2 = instr[24:20];
        case (funct3)
          3'b000:  dec_bundle.alu_ctrl = C_BEQ;
          3'b001:  dec_bundle.alu_ctrl = C_BNE;
          3'b100:  dec_bundle.alu_ctrl = C_BLT;
          3'b101:  dec_bundle.alu_ctrl = C_BGE;
          3'b110:  dec_bundle.alu_ctrl = C_BLTU;
          3'b111:  dec_bundle.alu_ctrl = C_BGEU;
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_bundle.alu_ctrl = C_JAL;
        dec_bundle.pcsrc    = 1'b1;
        dec_bundle.immsrc   = 1'b1;
        dec_bundle.imm      = imm_j;
        dec_bundle.rd       = instr[11:7];
        dec_bundle.reg_wen  = 1'b1;
      end
      OPC_JALR: begin
        dec_bundle.alu_ctrl = C_JALR;
        dec_bundle.pcsrc    = 1'b1;
        dec_bundle.immsrc   = 1'b1;
        dec_bundle.imm      = imm_i;
        dec_bundle.rs1      = instr[19:15];
        dec_bundle.rd       = instr[11:7];
        dec_bundle.reg_wen  = 1'b1;
        dec_bad             = (funct3 != 3'b000);
      end
      OPC_AUIPC: begin
        dec_bundle.alu_ctrl = C_AUIPC;
        dec_bundle.pcsrc    = 1'b1;
        dec_bundle.immsrc   = 1'b1;
        dec_bundle.imm      = imm_u;
        dec_bundle.rd       = instr[11:7];
        dec_bundle.reg_wen  = 1'b1;
      end
      OPC_LUI: begin
        // rs1 stays 0 so the ALU computes x0 + imm.
        dec_bundle.immsrc  = 1'b1;
        dec_bundle.imm     = imm_u;
        dec_bundle.rd      = instr[11:7];
        dec_bundle.reg_wen = 1'b1;
      end
      OPC_FENCE: begin
        dec_bundle.alu_ctrl = C_ADD;
      end
      default: begin
        dec_bad = 1'b1;
      end
    endcase
    // Anything undecodable collapses to a flagged NOP so nothing downstream fires.
    if (dec_bad) begin
      dec_bundle         = clear_bundle();
      dec_bundle.pc      = pc_in;
      dec_bundle.illegal = 1'b1;
    end else begin
      dec_bundle.illegal = 1'b0;
    end
  end

  bundle_t bundle_q, bundle_d;
  logic    out_valid_q, out_valid_d;
  logic    accept;

`ifdef ID_SKID_BUFFER_EN
  bundle_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q && !flush;

  // Two-entry pipe: the skid entry catches an accept during a stall and drains first.
  always_comb begin
    bundle_d     = bundle_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        bundle_d     = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        bundle_d    = dec_bundle;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_d       = dec_bundle;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers for the output entry, the skid entry and registered in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q     <= clear_bundle();
      out_valid_q  <= 1'b0;
      skid_q       <= clear_bundle();
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      bundle_q     <= bundle_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Single output register: flush kills, accept replaces, consume empties, else hold.
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      bundle_d    = dec_bundle;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers for the output bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= clear_bundle();
      out_valid_q <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif

  assign out_valid  = out_valid_q;
  assign pc_out     = bundle_q.pc;
  assign alu_ctrl   = bundle_q.alu_ctrl;
  assign alu_pcsrc  = bundle_q.pcsrc;
  assign alu_immsrc = bundle_q.immsrc;
  assign imm        = bundle_q.imm;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;
  assign rd         = bundle_q.rd;
  assign reg_wen    = bundle_q.reg_wen;
  assign mem_ren    = bundle_q.mem_ren;
  assign mem_wen    = bundle_q.mem_wen;
  assign mem_funct3 = bundle_q.mem_funct3;
  assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed plus random stimulus for id_decode_stage,
// checked against a queue-based reference of accepted instructions.
module tb_id_decode_stage;

  localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2,  A_SLT = 5'd3;
  localparam logic [4:0] A_SLTU = 5'd4, A_XOR = 5'd5,  A_SRL = 5'd6,  A_SRA = 5'd7;
  localparam logic [4:0] A_OR = 5'd8,   A_AND = 5'd9,  A_BEQ = 5'd10, A_BNE = 5'd11;
  localparam logic [4:0] A_BLT = 5'd12, A_BGE = 5'd13, A_BLTU = 5'd14, A_BGEU = 5'd15;
  localparam logic [4:0] A_JAL = 5'd16, A_JALR = 5'd17, A_AUIPC = 5'd18;

  localparam logic [4:0] R_OPS [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  localparam logic [4:0] B_OPS [8] = '{A_BEQ, A_BNE, A_ADD, A_ADD, A_BLT, A_BGE, A_BLTU, A_BGEU};
  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                      7'h67, 7'h17, 7'h37, 7'h0F, 7'h73};

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc_in, pc_out, imm;
  logic [4:0]  alu_ctrl, rs1, rs2, rd;
  logic        alu_pcsrc, alu_immsrc, reg_wen, mem_ren, mem_wen, illegal;
  logic [2:0]  mem_funct3;
  logic [92:0] obs;

  int checks = 0;
  int errors = 0;
  logic [92:0] q[$];

  always #5 clk = ~clk;

  id_decode_stage #(.XLEN(32), .CTRL_BITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .alu_ctrl(alu_ctrl),
    .alu_pcsrc(alu_pcsrc), .alu_immsrc(alu_immsrc), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_wen(reg_wen), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_funct3(mem_funct3), .illegal(illegal)
  );

  assign obs = {pc_out, alu_ctrl, alu_pcsrc, alu_immsrc, imm, rs1, rs2, rd,
                reg_wen, mem_ren, mem_wen, mem_funct3, illegal};

  task automatic chk(input string tag, input logic [92:0] o, input logic [92:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference decode: field extraction by arithmetic, op choice by tables.
  function automatic logic [92:0] ref_bundle(input logic [31:0] ins, input logic [31:0] pc);
    logic [6:0] op, f7; logic [2:0] f3, mf;
    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, im;
    logic [4:0] ctrl, r1, r2, rdv;
    logic pcs, ims, wen, ren, mw, ill;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    i_imm = $signed(ins) >>> 20;
    s_imm = $signed({ins[31:25], ins[11:7], 20'd0}) >>> 20;
    b_imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'd0}) >>> 19;
    j_imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'd0}) >>> 11;
    u_imm = ins & 32'hFFFF_F000;
    ctrl = A_ADD; pcs = 1'b0; ims = 1'b0; wen = 1'b0; ren = 1'b0; mw = 1'b0; ill = 1'b0;
    im = 32'd0; r1 = 5'd0; r2 = 5'd0; rdv = 5'd0; mf = 3'd0;
    if (op == 7'h33) begin
      wen = 1'b1; r1 = ins[19:15]; r2 = ins[24:20]; rdv = ins[11:7];
      if (f7 == 7'h00) ctrl = R_OPS[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) ctrl = A_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) ctrl = A_SRA;
      else ill = 1'b1;
    end else if (op == 7'h13) begin
      wen = 1'b1; ims = 1'b1; r1 = ins[19:15]; rdv = ins[11:7]; im = i_imm; ctrl = R_OPS[f3];
      if (f3 == 3'd1 || f3 == 3'd5) begin
        im = {27'd0, ins[24:20]};
        if (f7 == 7'h20 && f3 == 3'd5) ctrl = A_SRA;
        else if (f7 != 7'h00) ill = 1'b1;
      end
    end else if (op == 7'h03) begin
      ims = 1'b1; im = i_imm; ren = 1'b1; wen = 1'b1; r1 = ins[19:15]; rdv = ins[11:7]; mf = f3;
      ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end else if (op == 7'h23) begin
      ims = 1'b1; im = s_imm; mw = 1'b1; r1 = ins[19:15]; r2 = ins[24:20]; mf = f3;
      ill = (f3 > 3'd2);
    end else if (op == 7'h63) begin
      im = b_imm; r1 = ins[19:15]; r2 = ins[24:20]; ctrl = B_OPS[f3];
      ill = (f3 == 3'd2) || (f3 == 3'd3);
    end else if (op == 7'h6F) begin
      ctrl = A_JAL; pcs = 1'b1; ims = 1'b1; im = j_imm; rdv = ins[11:7]; wen = 1'b1;
    end else if (op == 7'h67) begin
      ctrl = A_JALR; pcs = 1'b1; ims = 1'b1; im = i_imm; r1 = ins[19:15]; rdv = ins[11:7];
      wen = 1'b1; ill = (f3 != 3'd0);
    end else if (op == 7'h17) begin
      ctrl = A_AUIPC; pcs = 1'b1; ims = 1'b1; im = u_imm; rdv = ins[11:7]; wen = 1'b1;
    end else if (op == 7'h37) begin
      ims = 1'b1; im = u_imm; rdv = ins[11:7]; wen = 1'b1;
    end else if (op == 7'h0F) begin
      ctrl = A_ADD;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      ctrl = A_ADD; pcs = 1'b0; ims = 1'b0; wen = 1'b0; ren = 1'b0; mw = 1'b0;
      im = 32'd0; r1 = 5'd0; r2 = 5'd0; rdv = 5'd0; mf = 3'd0;
    end
    return {pc, ctrl, pcs, ims, im, r1, r2, rdv, wen, ren, mw, mf, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w; logic [3:0] sel;
    w = $urandom();
    sel = 4'($urandom_range(0, 11));
    if (sel < 4'd11) w[6:0] = OPS[sel];
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // One clock: drive inputs, check outputs/in_ready against the queue model, update it.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                     input logic ordy, input logic fl, output logic acc);
    logic exp_rdy;
    in_valid = iv; instr = ins; pc_in = p; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk("out_valid", 93'(out_valid), 93'(q.size() != 0));
    if (q.size() != 0 && out_valid === 1'b1) chk("bundle", obs, q[0]);
`ifdef ID_SKID_BUFFER_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    if (!fl) chk("in_ready", 93'(in_ready), 93'(exp_rdy));
    acc = iv && exp_rdy && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(ref_bundle(ins, p));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [31:0] cur, pc;
    logic [31:0] stall_seq [4];
    int idx;
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc_in = 32'd0; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 93'(out_valid), 93'd0);
    chk("rst_in_ready", 93'(in_ready), 93'd1);
    chk("rst_bundle", obs, 93'd0);

    cyc(1'b1, 32'h002081B3, 32'h0000_0100, 1'b1, 1'b0, acc);
    chk("add_valid", 93'(out_valid), 93'd1);
    chk("add_ctrl", 93'(alu_ctrl), 93'(A_ADD));
    chk("add_src", 93'({alu_immsrc, alu_pcsrc}), 93'd0);
    chk("add_regs", 93'({rs1, rs2, rd}), 93'({5'd1, 5'd2, 5'd3}));
    chk("add_wen", 93'(reg_wen), 93'd1);
    chk("add_pc", 93'(pc_out), 93'h100);

    cyc(1'b1, 32'hFE208CE3, 32'h0000_0104, 1'b1, 1'b0, acc);
    chk("beq_ctrl", 93'(alu_ctrl), 93'(A_BEQ));
    chk("beq_imm", 93'(imm), 93'hFFFF_FFF8);
    chk("beq_wen", 93'(reg_wen), 93'd0);

    cyc(1'b1, 32'h00512623, 32'h0000_0108, 1'b1, 1'b0, acc);
    chk("sw_ctrl", 93'(alu_ctrl), 93'(A_ADD));
    chk("sw_imm", 93'({alu_immsrc, imm}), 93'({1'b1, 32'h0000_000C}));
    chk("sw_mem", 93'({mem_wen, mem_ren, reg_wen, mem_funct3}), 93'({3'b100, 3'b010}));
    chk("sw_regs", 93'({rs1, rs2}), 93'({5'd2, 5'd5}));

    cyc(1'b1, 32'h123452B7, 32'h0000_010C, 1'b1, 1'b0, acc);
    chk("lui_imm", 93'(imm), 93'h1234_5000);
    chk("lui_regs", 93'({rs1, rd, alu_immsrc}), 93'({5'd0, 5'd5, 1'b1}));

    cyc(1'b1, 32'hFFF00093, 32'h0000_0110, 1'b1, 1'b0, acc);
    chk("addi_imm", 93'(imm), 93'hFFFF_FFFF);

    cyc(1'b1, 32'h00000073, 32'h0000_0114, 1'b1, 1'b0, acc);
    chk("ecall_illegal", 93'(illegal), 93'd1);
    chk("ecall_en", 93'({reg_wen, mem_ren, mem_wen}), 93'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    // Stall: execute holds off for 3 cycles while fetch keeps offering.
    stall_seq[0] = 32'h00208233; stall_seq[1] = 32'h40208233;
    stall_seq[2] = 32'h0040A303; stall_seq[3] = 32'h008000EF;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, stall_seq[idx], 32'h200 + 32'(idx * 4), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    for (int c = 0; c < 20 && idx < 4; c++) begin
      cyc(1'b1, stall_seq[idx], 32'h200 + 32'(idx * 4), 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    // Flush: pending bundle plus an offered instruction both vanish.
    cyc(1'b1, 32'h00300193, 32'h300, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h00500293, 32'h304, 1'b0, 1'b1, acc);
    chk("flush_valid", 93'(out_valid), 93'd0);
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    // Random traffic; fetch holds an instruction until it is accepted.
    cur = rand_instr(); pc = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(0, 3) != 0), cur, pc, ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 31) == 0), acc);
      if (acc) begin
        cur = rand_instr();
        pc  = pc + 32'd4;
      end
    end
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
